// File: rtl/conv2d_window_mac_if.sv
// Bundle of the conv2d compute-stage signals: parameter/weight loading,
// the input pixel stream, the partial-sum FIFO read port, the result
// stream and the status flags. The master side drives stimulus and the
// slave side is the MAC block.
interface conv2d_window_mac_if #(
    parameter int KS = 3
);
    logic                  param_ena;
    logic [8:0]            width_in;
    logic [8:0]            height_in;
    logic                  w_load;
    logic [KS*KS*32-1:0]   pxl_w;
    logic                  pxl_ena_x;
    logic [31:0]           pxl_x;
    logic                  pxl_ena_y;
    logic [31:0]           pxl_y;
    logic                  out_valid;
    logic [31:0]           out_data;
    logic                  busy;
    logic                  done;
    logic                  param_err;
    logic                  drop_err;

    modport master (
        output param_ena, width_in, height_in, w_load, pxl_w,
        output pxl_ena_x, pxl_x, pxl_y,
        input  pxl_ena_y, out_valid, out_data, busy, done, param_err, drop_err
    );

    modport slave (
        input  param_ena, width_in, height_in, w_load, pxl_w,
        input  pxl_ena_x, pxl_x, pxl_y,
        output pxl_ena_y, out_valid, out_data, busy, done, param_err, drop_err
    );
endinterface

// File: rtl/conv2d_window_mac.sv
// Sliding-window KSxKS multiply-accumulate for a "valid"-mode 2D
// convolution. Pixels arrive in raster order without backpressure; KS-1
// line buffers hold the previous rows, a KSxKS shift-register window feeds
// KS*KS signed multipliers, and the product sum plus the partial sum read
// from the upstream FIFO is saturated to signed Q16.16.
module conv2d_window_mac #(
    parameter int KS   = 3,
    parameter int MAXW = 256,
    parameter int FRAC = 16
) (
    input  logic              clk,
    input  logic              rst,
    conv2d_window_mac_if.slave bus
);
    localparam int AW = $clog2(MAXW);
    localparam int NW = KS * KS;
    localparam logic signed [67:0] SAT_MAX = 68'sh0_7FFF_FFFF;
    localparam logic signed [67:0] SAT_MIN = -68'sh0_8000_0000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t      state_q;
    logic [8:0]  width_q, height_q;
    logic [8:0]  col_q, row_q, col_d, row_d;
    logic [1:0]  flush_cnt_q;
    logic        busy_q, done_q, param_err_q, drop_err_q;

    logic [31:0] w_q   [NW];
    logic [31:0] win_q [KS][KS];
    logic [31:0] new_col [KS];
    logic [KS-2:0][31:0] lb_rd;

    logic        accept, last_pix, win_valid, size_ok, param_take;
    logic        vld1_q, vld2_q, out_valid_q;
    logic [31:0] out_data_q;
    logic signed [63:0] prod_q [NW];
    logic signed [67:0] acc_sum, acc_tot;
    logic [31:0] sat_val;

    assign accept     = bus.pxl_ena_x && (state_q == S_RUN);
    assign last_pix   = accept && (row_q == height_q - 9'd1) && (col_q == width_q - 9'd1);
    assign win_valid  = accept && (row_q >= 9'(KS - 1)) && (col_q >= 9'(KS - 1));
    assign size_ok    = (bus.width_in >= 9'(KS)) && (bus.width_in <= 9'(MAXW)) &&
                        (bus.height_in >= 9'(KS));
    assign param_take = (state_q == S_IDLE) && bus.param_ena;

    // Control FSM with registered status outputs; flush covers the 3-cycle MAC drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            flush_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            param_err_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.pxl_ena_x && (state_q != S_RUN)) begin
                drop_err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.param_ena) begin
                        // An accepted start clears the sticky flags; a pixel in
                        // this same cycle is still a drop.
                        param_err_q <= !size_ok;
                        drop_err_q  <= bus.pxl_ena_x;
                        if (size_ok) begin
                            width_q  <= bus.width_in;
                            height_q <= bus.height_in;
                            busy_q   <= 1'b1;
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (last_pix) begin
                        flush_cnt_q <= '0;
                        state_q     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + 2'd1;
                    // done is timed to coincide with the final out_valid
                    if (flush_cnt_q == 2'd1) begin
                        done_q <= 1'b1;
                    end
                    if (flush_cnt_q == 2'd2) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Next raster position; also the read address of the line buffers
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (param_take) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == width_q - 9'd1) begin
                col_d = '0;
                row_d = row_q + 9'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    // Raster position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line buffers form a cascade: buffer 0 stores the incoming row, buffer
    // k stores what buffer k-1 held for the same column. The read is
    // registered at the address of the next pixel so the data is ready when
    // that pixel arrives, however long the gap.
    genvar gi;
    generate
        for (gi = 0; gi < KS - 1; gi++) begin : g_lb
            logic [31:0] mem [MAXW];
            logic [31:0] rd_q;
            logic [31:0] wr_data;
            if (gi == 0) begin : g_head
                assign wr_data = bus.pxl_x;
            end else begin : g_chain
                assign wr_data = lb_rd[gi-1];
            end
            // Write current column, prefetch next column
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_q[AW-1:0]] <= wr_data;
                end
                rd_q <= mem[col_d[AW-1:0]];
            end
            assign lb_rd[gi] = rd_q;
        end

        // Newest window column: oldest row at index 0, live pixel at KS-1
        for (gi = 0; gi < KS; gi++) begin : g_col
            if (gi == KS - 1) begin : g_live
                assign new_col[gi] = bus.pxl_x;
            end else begin : g_buf
                assign new_col[gi] = lb_rd[KS-2-gi];
            end
        end
    endgenerate

    // Weight registers, loadable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
        end else if ((state_q == S_IDLE) && bus.w_load) begin
            for (int k = 0; k < NW; k++) w_q[k] <= bus.pxl_w[32*k +: 32];
        end
    end

    // Window shift: columns move left, newest column enters at KS-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < KS; r++)
                for (int c = 0; c < KS; c++) win_q[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < KS; r++) begin
                for (int c = 0; c < KS - 1; c++) win_q[r][c] <= win_q[r][c+1];
                win_q[r][KS-1] <= new_col[r];
            end
        end
    end

    // Adder tree over the products, Q32.32 -> Q16.16, plus partial sum, saturate
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < NW; k++) begin
            acc_sum = acc_sum + $signed({{4{prod_q[k][63]}}, prod_q[k]});
        end
        acc_tot = (acc_sum >>> FRAC) + $signed({{36{bus.pxl_y[31]}}, bus.pxl_y});
        if (acc_tot > SAT_MAX) begin
            sat_val = 32'h7FFF_FFFF;
        end else if (acc_tot < SAT_MIN) begin
            sat_val = 32'h8000_0000;
        end else begin
            sat_val = acc_tot[31:0];
        end
    end

    // Three-stage MAC pipeline: FIFO read + multiply, sum, output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < NW; k++) prod_q[k] <= '0;
        end else begin
            vld1_q      <= win_valid;
            vld2_q      <= vld1_q;
            out_valid_q <= vld2_q;
            if (vld1_q) begin
                for (int k = 0; k < NW; k++) begin
                    prod_q[k] <= $signed(win_q[k/KS][k%KS]) * $signed(w_q[k]);
                end
            end
            if (vld2_q) begin
                out_data_q <= sat_val;
            end
        end
    end

    assign bus.pxl_ena_y = vld1_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.param_err = param_err_q;
    assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_conv2d_window_mac.sv
// Directed bench for conv2d_window_mac: small images with hand-computed
// window sums, partial-sum timing, weight placement, saturation, size
// errors, a wide image with stream gaps, and reset in the middle of a run.
module tb_conv2d_window_mac;
    localparam int KS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv2d_window_mac_if #(.KS(KS)) bus ();
    conv2d_window_mac #(.KS(KS), .MAXW(256), .FRAC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int          out_cyc  [$];
    logic [31:0] out_val  [$];
    int          eny_cyc  [$];
    int          done_cyc [$];
    int          pix_cyc  [$];
    logic [31:0] y_val  = 32'h0;
    bit          y_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus partial-sum FIFO model (data valid the cycle after a read)
    always @(negedge clk) begin
        if (bus.out_valid) begin
            out_cyc.push_back(cyc);
            out_val.push_back(bus.out_data);
        end
        if (bus.pxl_ena_y) eny_cyc.push_back(cyc);
        if (bus.done) done_cyc.push_back(cyc);
        bus.pxl_y = y_pend ? y_val : 32'h7777_0000;
        y_pend    = bus.pxl_ena_y;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pix(input int mode, input int r, input int c, input int w);
        if (mode == 0) return 32'((r * w + c) << 16);
        else if (mode == 1) return 32'h7FFF_0000;
        else return 32'h8000_0000;
    endfunction

    task automatic load_w(input logic [KS*KS*32-1:0] wv);
        step();
        bus.w_load = 1'b1;
        bus.pxl_w  = wv;
        step();
        bus.w_load = 1'b0;
    endtask

    task automatic run_img(input int w, input int h, input int mode, input bit gaps);
        int t;
        out_cyc.delete(); out_val.delete(); eny_cyc.delete();
        done_cyc.delete(); pix_cyc.delete();
        step();
        bus.param_ena = 1'b1;
        bus.width_in  = 9'(w);
        bus.height_in = 9'(h);
        for (int i = 0; i < w * h; i++) begin
            step();
            bus.param_ena = 1'b0;
            if (gaps && (i % 5 == 4)) begin
                bus.pxl_ena_x = 1'b0;
                step();
            end
            bus.pxl_ena_x = 1'b1;
            bus.pxl_x     = pix(mode, i / w, i % w, w);
            pix_cyc.push_back(cyc);
        end
        step();
        bus.pxl_ena_x = 1'b0;
        t = 0;
        while (done_cyc.size() == 0 && t < 100) begin
            step();
            t++;
        end
        n_vec++;
        if (done_cyc.size() == 0) begin
            n_bad++;
            $display("FAIL done_timeout: got no done within %0d cycles, want one", t);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [38:0] got;
        step();
        got = {bus.out_valid, bus.out_data, bus.busy, bus.done, bus.param_err,
               bus.drop_err, bus.pxl_ena_y, 1'b0};
        n_vec++;
        if (got !== 39'h0) begin
            n_bad++;
            $display("FAIL reset_in: got %h want 0", got);
        end
        rst = 1'b0;
        repeat (2) step();
        got = {bus.out_valid, bus.out_data, bus.busy, bus.done, bus.param_err,
               bus.drop_err, bus.pxl_ena_y, 1'b0};
        n_vec++;
        if (got !== 39'h0) begin
            n_bad++;
            $display("FAIL reset_after: got %h want 0", got);
        end
    endtask

    task automatic check4(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev [4];
        ev = '{e0, e1, e2, e3};
        n_vec++;
        if (out_val.size() != 4) begin
            n_bad++;
            $display("FAIL %s_count: got %0d outputs want 4", nm, out_val.size());
        end
        for (int i = 0; i < 4 && i < out_val.size(); i++) begin
            n_vec++;
            if (out_val[i] !== ev[i]) begin
                n_bad++;
                $display("FAIL %s_out[%0d]: got %h want %h", nm, i, out_val[i], ev[i]);
            end
        end
    endtask

    task automatic test_basic();
        load_w({9{32'h0001_0000}});
        y_val = 32'h0;
        run_img(4, 4, 0, 1'b0);
        check4("basic", 32'h002D_0000, 32'h0036_0000, 32'h0051_0000, 32'h005A_0000);
        n_vec++;
        if (eny_cyc.size() != 4) begin
            n_bad++;
            $display("FAIL basic_ena_y: got %0d reads want 4", eny_cyc.size());
        end
        n_vec++;
        if (done_cyc.size() != 1 || out_cyc.size() == 0 || done_cyc[0] != out_cyc[out_cyc.size()-1]) begin
            n_bad++;
            $display("FAIL basic_done: got %0d pulses want 1 with last output", done_cyc.size());
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_end: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_psum_timing();
        int idx [4];
        idx = '{10, 11, 14, 15};
        y_val = 32'h0001_0000;
        run_img(4, 4, 0, 1'b0);
        check4("psum", 32'h002E_0000, 32'h0037_0000, 32'h0052_0000, 32'h005B_0000);
        for (int i = 0; i < 4 && i < out_cyc.size() && i < eny_cyc.size(); i++) begin
            n_vec++;
            if (out_cyc[i] != pix_cyc[idx[i]] + 3 || eny_cyc[i] != pix_cyc[idx[i]] + 1) begin
                n_bad++;
                $display("FAIL psum_timing[%0d]: got out@%0d ena_y@%0d want out@%0d ena_y@%0d",
                         i, out_cyc[i], eny_cyc[i], pix_cyc[idx[i]] + 3, pix_cyc[idx[i]] + 1);
            end
        end
        y_val = 32'h0;
    endtask

    task automatic test_weight_map();
        logic [KS*KS*32-1:0] wv;
        wv = '0;
        wv[0 +: 32] = 32'h0001_0000;
        load_w(wv);
        run_img(4, 4, 0, 1'b0);
        check4("wslot0", 32'h0000_0000, 32'h0001_0000, 32'h0004_0000, 32'h0005_0000);
        wv = '0;
        wv[32*5 +: 32] = 32'h0001_0000;
        load_w(wv);
        run_img(4, 4, 0, 1'b0);
        check4("wslot5", 32'h0006_0000, 32'h0007_0000, 32'h000A_0000, 32'h000B_0000);
    endtask

    task automatic test_saturation();
        load_w({9{32'h0001_0000}});
        run_img(3, 3, 1, 1'b0);
        n_vec++;
        if (out_val.size() != 1 || out_val[0] !== 32'h7FFF_FFFF) begin
            n_bad++;
            $display("FAIL sat_pos: got %0d outs first %h want 1 out 7fffffff",
                     out_val.size(), (out_val.size() > 0) ? out_val[0] : 32'h0);
        end
        run_img(3, 3, 2, 1'b0);
        n_vec++;
        if (out_val.size() != 1 || out_val[0] !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL sat_neg: got %0d outs first %h want 1 out 80000000",
                     out_val.size(), (out_val.size() > 0) ? out_val[0] : 32'h0);
        end
    endtask

    task automatic test_param_err();
        int bad_w [2];
        bad_w = '{2, 300};
        for (int i = 0; i < 2; i++) begin
            step();
            bus.param_ena = 1'b1;
            bus.width_in  = 9'(bad_w[i]);
            bus.height_in = 9'd4;
            step();
            bus.param_ena = 1'b0;
            repeat (2) step();
            n_vec++;
            if (bus.param_err !== 1'b1 || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL param_err_w%0d: got err=%b busy=%b want err=1 busy=0",
                         bad_w[i], bus.param_err, bus.busy);
            end
        end
        bus.pxl_ena_x = 1'b1;
        bus.pxl_x     = 32'h1234_5678;
        step();
        bus.pxl_ena_x = 1'b0;
        step();
        n_vec++;
        if (bus.drop_err !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_idle: got %b want 1", bus.drop_err);
        end
        run_img(3, 3, 0, 1'b0);
        n_vec++;
        if (bus.param_err !== 1'b0 || bus.drop_err !== 1'b0) begin
            n_bad++;
            $display("FAIL flags_clear: got err=%b drop=%b want 0 0", bus.param_err, bus.drop_err);
        end
        n_vec++;
        if (out_val.size() != 1 || out_val[0] !== 32'h0024_0000) begin
            n_bad++;
            $display("FAIL legal_after_err: got %0d outs first %h want 1 out 00240000",
                     out_val.size(), (out_val.size() > 0) ? out_val[0] : 32'h0);
        end
    endtask

    task automatic test_wide_gaps();
        logic [31:0] ev;
        run_img(256, 3, 0, 1'b1);
        n_vec++;
        if (out_val.size() != 254 || eny_cyc.size() != 254) begin
            n_bad++;
            $display("FAIL wide_count: got %0d outs %0d reads want 254 254",
                     out_val.size(), eny_cyc.size());
        end
        for (int i = 0; i < 254 && i < out_val.size(); i++) begin
            ev = 32'((2295 + 9 * (i + 2)) << 16);
            n_vec++;
            if (out_val[i] !== ev) begin
                n_bad++;
                $display("FAIL wide_out[%0d]: got %h want %h", i, out_val[i], ev);
            end
        end
        bus.pxl_ena_x = 1'b1;
        step();
        bus.pxl_ena_x = 1'b0;
        step();
        n_vec++;
        if (bus.drop_err !== 1'b1) begin
            n_bad++;
            $display("FAIL wide_drop: got %b want 1", bus.drop_err);
        end
    endtask

    task automatic test_midrun_reset();
        load_w({9{32'h0001_0000}});
        step();
        bus.param_ena = 1'b1;
        bus.width_in  = 9'd4;
        bus.height_in = 9'd4;
        for (int i = 0; i < 7; i++) begin
            step();
            bus.param_ena = 1'b0;
            bus.pxl_ena_x = 1'b1;
            bus.pxl_x     = pix(0, i / 4, i % 4, 4);
        end
        step();
        bus.pxl_ena_x = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_busy: got %b want 1", bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.pxl_ena_y !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_async: got busy=%b ov=%b ena_y=%b want 0 0 0",
                     bus.busy, bus.out_valid, bus.pxl_ena_y);
        end
        step();
        rst = 1'b0;
        step();
        run_img(4, 4, 0, 1'b0);
        check4("noweights", 32'h0, 32'h0, 32'h0, 32'h0);
        load_w({9{32'h0001_0000}});
        run_img(4, 4, 0, 1'b0);
        check4("after_rst", 32'h002D_0000, 32'h0036_0000, 32'h0051_0000, 32'h005A_0000);
    endtask

    initial begin
        bus.param_ena = 1'b0;
        bus.width_in  = '0;
        bus.height_in = '0;
        bus.w_load    = 1'b0;
        bus.pxl_w     = '0;
        bus.pxl_ena_x = 1'b0;
        bus.pxl_x     = '0;
        repeat (3) step();
        test_reset();
        test_basic();
        test_psum_timing();
        test_weight_map();
        test_saturation();
        test_param_err();
        test_wide_gaps();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
